vfu_mask_dispatch: RTL and testbench

- Per-lane mask distribution stage between the mask unit broadcast and a parametrised set of lane functional units (ALU, MFPU, further FUs).
- Each mask beat carries the vector instruction ID (vid). The block routes the beat only to the FU currently executing that vid, so several masked instructions can run concurrently in different FUs without a beat being accepted by more than one unit.
- Per-FU FIFOs decouple the mask broadcast from FU consumption.
- A sticky, clearable saturation (vxsat) aggregator over all FUs is also included.

---
 rtl/vfu_mask_dispatch.sv | 136 +++++++++++++
 tb/tb_vfu_mask_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_mask_dispatch.sv
// Routes each mask beat to the FU executing its vid through per-FU FIFOs,
// and keeps a sticky, clearable OR of all FU saturation events.
module vfu_mask_dispatch #(
  parameter int unsigned NrFUs     = 2,
  parameter int unsigned StrbWidth = 8,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned NrVInsn   = 8,
  localparam int unsigned VidW     = (NrVInsn > 1) ? $clog2(NrVInsn) : 1,
  localparam int unsigned CntW     = $clog2(FifoDepth + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [StrbWidth-1:0]       mask_i,
  input  logic [VidW-1:0]            mask_vid_i,
  input  logic                       mask_valid_i,
  output logic                       mask_ready_o,
  input  logic [NrFUs*VidW-1:0]      fu_vid_i,
  input  logic [NrFUs-1:0]           fu_vid_valid_i,
  input  logic [NrFUs-1:0]           fu_flush_i,
  output logic [NrFUs*StrbWidth-1:0] fu_mask_o,
  output logic [NrFUs-1:0]           fu_mask_valid_o,
  input  logic [NrFUs-1:0]           fu_mask_ready_i,
  output logic [NrFUs*CntW-1:0]      fu_mask_cnt_o,
  output logic                       mask_multi_hit_o,
  input  logic [NrFUs-1:0]           vxsat_i,
  input  logic                       vxsat_clr_i,
  output logic                       vxsat_flag_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned TgtW = (NrFUs > 1) ? $clog2(NrFUs) : 1;

  logic [StrbWidth-1:0]            mem_q [NrFUs][FifoDepth];
  logic [StrbWidth-1:0]            mem_d [NrFUs][FifoDepth];
  logic [NrFUs-1:0][PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [NrFUs-1:0][CntW-1:0]      cnt_q, cnt_d;
  logic                            multi_hit_q, multi_hit_d;
  logic                            vxsat_q, vxsat_d;

  logic [NrFUs-1:0]                hit;
  logic                            any_hit, multi;
  logic [TgtW-1:0]                 tgt;
  logic                            accept;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Descending scan so the lowest hitting FU is the one left in tgt.
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    multi   = 1'b0;
    tgt     = '0;
    for (int k = NrFUs - 1; k >= 0; k--) begin
      hit[k] = fu_vid_valid_i[k] && (fu_vid_i[k*VidW +: VidW] == mask_vid_i);
      if (hit[k]) begin
        if (any_hit) multi = 1'b1;
        any_hit = 1'b1;
        tgt     = TgtW'(k);
      end
    end
  end

  // Acceptance looks only at the full flag, never at a same-cycle pop.
  always_comb begin
    accept = !rst_i && mask_valid_i && any_hit &&
             (cnt_q[tgt] != CntW'(FifoDepth)) && !fu_flush_i[tgt];
  end

  assign mask_ready_o = accept;

  always_comb begin
    logic push, pop;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    pop   = 1'b0;
    for (int k = 0; k < NrFUs; k++) begin
      push = accept && (tgt == TgtW'(k));
      pop  = (cnt_q[k] != '0) && fu_mask_ready_i[k];
      if (fu_flush_i[k]) begin
        cnt_d[k] = '0;
        wr_d[k]  = '0;
        rd_d[k]  = '0;
      end else begin
        if (push) begin
          mem_d[k][wr_q[k]] = mask_i;
          wr_d[k]           = next_ptr(wr_q[k]);
        end
        if (pop) rd_d[k] = next_ptr(rd_q[k]);
        cnt_d[k] = cnt_q[k] + CntW'(push) - CntW'(pop);
      end
    end
    multi_hit_d = accept && multi;
    vxsat_d     = (vxsat_q && !vxsat_clr_i) || (|vxsat_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NrFUs; k++) begin
        for (int d = 0; d < FifoDepth; d++) mem_q[k][d] <= '0;
      end
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      multi_hit_q <= 1'b0;
      vxsat_q     <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      multi_hit_q <= multi_hit_d;
      vxsat_q     <= vxsat_d;
    end
  end

  // Head data is zeroed when empty so stale entries never leak out.
  always_comb begin
    fu_mask_o       = '0;
    fu_mask_valid_o = '0;
    fu_mask_cnt_o   = '0;
    for (int k = 0; k < NrFUs; k++) begin
      fu_mask_valid_o[k] = (cnt_q[k] != '0);
      fu_mask_cnt_o[k*CntW +: CntW] = cnt_q[k];
      if (cnt_q[k] != '0) fu_mask_o[k*StrbWidth +: StrbWidth] = mem_q[k][rd_q[k]];
    end
  end

  assign mask_multi_hit_o = multi_hit_q;
  assign vxsat_flag_o     = vxsat_q;

endmodule

// File: tb/tb_vfu_mask_dispatch.sv
// Self-checking bench for vfu_mask_dispatch: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_vfu_mask_dispatch;
  localparam int NF = 2;
  localparam int SW = 8;
  localparam int FD = 2;
  localparam int VW = 3;
  localparam int CW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [SW-1:0]     mask_i;
  logic [VW-1:0]     mask_vid_i;
  logic              mask_valid_i;
  logic              mask_ready_o;
  logic [NF*VW-1:0]  fu_vid_i;
  logic [NF-1:0]     fu_vid_valid_i;
  logic [NF-1:0]     fu_flush_i;
  logic [NF*SW-1:0]  fu_mask_o;
  logic [NF-1:0]     fu_mask_valid_o;
  logic [NF-1:0]     fu_mask_ready_i;
  logic [NF*CW-1:0]  fu_mask_cnt_o;
  logic              mask_multi_hit_o;
  logic [NF-1:0]     vxsat_i;
  logic              vxsat_clr_i;
  logic              vxsat_flag_o;
  logic [VW-1:0]     vid0, vid1;

  assign fu_vid_i = {vid1, vid0};

  always #5 clk_i = ~clk_i;

  vfu_mask_dispatch #(.NrFUs(NF), .StrbWidth(SW), .FifoDepth(FD), .NrVInsn(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mask_i(mask_i), .mask_vid_i(mask_vid_i),
    .mask_valid_i(mask_valid_i), .mask_ready_o(mask_ready_o), .fu_vid_i(fu_vid_i),
    .fu_vid_valid_i(fu_vid_valid_i), .fu_flush_i(fu_flush_i), .fu_mask_o(fu_mask_o),
    .fu_mask_valid_o(fu_mask_valid_o), .fu_mask_ready_i(fu_mask_ready_i),
    .fu_mask_cnt_o(fu_mask_cnt_o), .mask_multi_hit_o(mask_multi_hit_o),
    .vxsat_i(vxsat_i), .vxsat_clr_i(vxsat_clr_i), .vxsat_flag_o(vxsat_flag_o)
  );

  a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (mask_valid_i && !mask_ready_o) |=> (mask_valid_i && $stable(mask_i) && $stable(mask_vid_i)))
    else $error("FAIL a_hold: beat dropped or changed before acceptance");
  a_empty0: assert property (@(posedge clk_i) disable iff (rst_i)
    (fu_mask_cnt_o[CW-1:0] == '0) |-> !fu_mask_valid_o[0])
    else $error("FAIL a_empty0: FU0 head valid while empty");
  a_empty1: assert property (@(posedge clk_i) disable iff (rst_i)
    (fu_mask_cnt_o[2*CW-1:CW] == '0) |-> !fu_mask_valid_o[1])
    else $error("FAIL a_empty1: FU1 head valid while empty");

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per FU plus the two sticky/pulse flags.
  logic [SW-1:0] mq [NF][$];
  bit  m_flag, m_multi, m_r;
  int  m_t, m_nh;

  task automatic model_clear();
    for (int k = 0; k < NF; k++) mq[k].delete();
    m_flag  = 1'b0;
    m_multi = 1'b0;
  endtask

  task automatic set_in(input logic [2:0] v0, input logic [2:0] v1, input logic [1:0] vv,
                        input logic [7:0] m, input logic [2:0] mv, input logic val,
                        input logic [1:0] rdy, input logic [1:0] fl, input logic [1:0] vx,
                        input logic clr);
    vid0 = v0; vid1 = v1; fu_vid_valid_i = vv; mask_i = m; mask_vid_i = mv;
    mask_valid_i = val; fu_mask_ready_i = rdy; fu_flush_i = fl; vxsat_i = vx;
    vxsat_clr_i = clr;
  endtask

  // Called at posedge+1 after inputs are set; checks the combinational ready.
  task automatic pre();
    logic [VW-1:0] v;
    #1;
    m_nh = 0;
    m_t  = -1;
    for (int k = 0; k < NF; k++) begin
      v = (k == 0) ? vid0 : vid1;
      if (fu_vid_valid_i[k] && v == mask_vid_i) begin
        m_nh++;
        if (m_t < 0) m_t = k;
      end
    end
    m_r = 1'b0;
    if (mask_valid_i && m_t >= 0) begin
      if (mq[m_t].size() < FD && !fu_flush_i[m_t]) m_r = 1'b1;
    end
    chk("mask_ready", mask_ready_o, m_r);
  endtask

  task automatic post();
    logic [SW-1:0] eh;
    @(posedge clk_i);
    for (int k = 0; k < NF; k++) begin
      if (fu_flush_i[k]) mq[k].delete();
      else if (mq[k].size() > 0 && fu_mask_ready_i[k]) void'(mq[k].pop_front());
    end
    if (m_r) mq[m_t].push_back(mask_i);
    m_multi = m_r && (m_nh > 1);
    m_flag  = (m_flag && !vxsat_clr_i) || (|vxsat_i);
    #1;
    for (int k = 0; k < NF; k++) begin
      eh = (mq[k].size() > 0) ? mq[k][0] : 8'h00;
      chk($sformatf("head_valid%0d", k), fu_mask_valid_o[k], mq[k].size() > 0);
      chk($sformatf("cnt%0d", k), fu_mask_cnt_o[k*CW +: CW], mq[k].size());
      chk($sformatf("head%0d", k), fu_mask_o[k*SW +: SW], eh);
    end
    chk("multi_hit", mask_multi_hit_o, m_multi);
    chk("vxsat_flag", vxsat_flag_o, m_flag);
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, mask_ready_o, 0);
    chk({tag, "_valid"}, fu_mask_valid_o, 0);
    chk({tag, "_cnt"}, fu_mask_cnt_o, 0);
    chk({tag, "_mask"}, fu_mask_o, 0);
    chk({tag, "_multi"}, mask_multi_hit_o, 0);
    chk({tag, "_flag"}, vxsat_flag_o, 0);
  endtask

  typedef struct {
    logic [2:0] v0; logic [2:0] v1; logic [1:0] vv; logic [7:0] m; logic [2:0] mv;
    logic val; logic [1:0] rdy; logic [1:0] fl; logic [1:0] vx; logic clr;
    logic er; logic [1:0] c0; logic [1:0] c1; logic [7:0] h0; logic [7:0] h1; logic ef;
  } vec_t;

  vec_t tbl [8];
  bit   pend;

  initial begin
    tbl[0] = '{3'd3, 3'd5, 2'b11, 8'hAA, 3'd5, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0,
               1'b1, 2'd0, 2'd1, 8'h00, 8'hAA, 1'b0};
    tbl[1] = '{3'd3, 3'd5, 2'b11, 8'h0F, 3'd3, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0,
               1'b1, 2'd1, 2'd1, 8'h0F, 8'hAA, 1'b0};
    tbl[2] = '{3'd3, 3'd5, 2'b11, 8'h00, 3'd0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{3'd3, 3'd5, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{3'd3, 3'd5, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1};
    tbl[5] = '{3'd3, 3'd5, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{3'd3, 3'd5, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1};
    tbl[7] = '{3'd3, 3'd5, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1,
               1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0};

    // Reset with a matching beat presented: nothing may be accepted.
    rst_i = 1'b1;
    set_in(3'd0, 3'd0, 2'b01, 8'hEE, 3'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    model_clear();
    #12;
    check_zero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    set_in(3'd0, 3'd0, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].v0, tbl[i].v1, tbl[i].vv, tbl[i].m, tbl[i].mv, tbl[i].val,
             tbl[i].rdy, tbl[i].fl, tbl[i].vx, tbl[i].clr);
      pre();
      chk($sformatf("tbl%0d_ready", i), mask_ready_o, tbl[i].er);
      post();
      chk($sformatf("tbl%0d_cnt0", i), fu_mask_cnt_o[1:0], tbl[i].c0);
      chk($sformatf("tbl%0d_cnt1", i), fu_mask_cnt_o[3:2], tbl[i].c1);
      chk($sformatf("tbl%0d_head0", i), fu_mask_o[7:0], tbl[i].h0);
      chk($sformatf("tbl%0d_head1", i), fu_mask_o[15:8], tbl[i].h1);
      chk($sformatf("tbl%0d_flag", i), vxsat_flag_o, tbl[i].ef);
    end

    // Full FIFO: third beat stalls, a pop while full does not let it in.
    set_in(3'd1, 3'd0, 2'b01, 8'h11, 3'd1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step();
    mask_i = 8'h22;
    step();
    chk("full_cnt0", fu_mask_cnt_o[1:0], 2);
    mask_i = 8'h33;
    pre();
    chk("full_stall", mask_ready_o, 0);
    post();
    fu_mask_ready_i = 2'b01;
    pre();
    chk("full_pop_no_accept", mask_ready_o, 0);
    post();
    chk("full_after_pop_head", fu_mask_o[7:0], 8'h22);
    fu_mask_ready_i = 2'b00;
    pre();
    chk("full_third_accept", mask_ready_o, 1);
    post();
    chk("full_cnt_back", fu_mask_cnt_o[1:0], 2);
    set_in(3'd1, 3'd0, 2'b01, 8'h00, 3'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    step();
    chk("full_order_third", fu_mask_o[7:0], 8'h33);
    step();
    chk("full_drained", fu_mask_cnt_o[1:0], 0);

    // Unclaimed vid stalls until an FU picks it up.
    set_in(3'd0, 3'd0, 2'b00, 8'h66, 3'd6, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pre();
      chk($sformatf("nohit_stall%0d", i), mask_ready_o, 0);
      post();
    end
    vid1 = 3'd6;
    fu_vid_valid_i = 2'b10;
    pre();
    chk("nohit_claimed", mask_ready_o, 1);
    post();
    chk("nohit_valid1", fu_mask_valid_o[1], 1);
    chk("nohit_head1", fu_mask_o[15:8], 8'h66);
    mask_valid_i = 1'b0;
    step();

    // Two FUs on the same vid: lowest index wins, one-cycle pulse.
    set_in(3'd2, 3'd2, 2'b11, 8'h55, 3'd2, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step();
    chk("multi_pulse", mask_multi_hit_o, 1);
    chk("multi_cnt0", fu_mask_cnt_o[1:0], 1);
    chk("multi_cnt1", fu_mask_cnt_o[3:2], 0);
    chk("multi_head0", fu_mask_o[7:0], 8'h55);
    mask_valid_i = 1'b0;
    step();
    chk("multi_pulse_end", mask_multi_hit_o, 0);
    fu_mask_ready_i = 2'b11;
    step();

    // Flush beats push and pop in the same cycle.
    set_in(3'd0, 3'd4, 2'b10, 8'h41, 3'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step();
    mask_i = 8'h42;
    step();
    chk("flush_pre_cnt1", fu_mask_cnt_o[3:2], 2);
    mask_i = 8'h43;
    fu_flush_i = 2'b10;
    fu_mask_ready_i = 2'b10;
    pre();
    chk("flush_blocks_push", mask_ready_o, 0);
    post();
    chk("flush_cnt1", fu_mask_cnt_o[3:2], 0);
    fu_flush_i = 2'b00;
    fu_mask_ready_i = 2'b00;
    pre();
    chk("flush_then_accept", mask_ready_o, 1);
    post();
    chk("flush_new_head", fu_mask_o[15:8], 8'h43);
    set_in(3'd0, 3'd4, 2'b10, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0);
    step();
    chk("rst_pre_flag", vxsat_flag_o, 1);

    // Asynchronous reset in mid-cycle with state and a live beat present.
    set_in(3'd3, 3'd4, 2'b11, 8'h77, 3'd3, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_zero("async_rst");
    model_clear();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    set_in(3'd0, 3'd0, 2'b00, 8'h00, 3'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    // Randomized traffic; an unaccepted beat is held unchanged.
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        mask_valid_i = ($urandom_range(0, 3) != 0);
        mask_i       = 8'($urandom);
        mask_vid_i   = 3'($urandom_range(0, 3));
        pend         = mask_valid_i;
      end
      if ($urandom_range(0, 3) == 0) begin
        vid0 = 3'($urandom_range(0, 3));
        vid1 = 3'($urandom_range(0, 3));
        fu_vid_valid_i = 2'($urandom);
      end
      fu_mask_ready_i = 2'($urandom);
      fu_flush_i      = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      vxsat_i         = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      vxsat_clr_i     = ($urandom_range(0, 7) == 0);
      pre();
      if (m_r) pend = 1'b0;
      post();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
